lsu_pipe: RTL and testbench



---
 rtl/lsu_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe -- RISC-V style load/store unit in front of a single-ported,
// NB-lane data memory (NB = DATA_W/8).
//
// One request at a time. A request is accepted in IDLE, issued to memory in
// ACC1 (and ACC2 for the upper half of a boundary-crossing access), then
// answered with a one-cycle resp_valid pulse in RESP.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split accesses that cross an
// NB-byte boundary into two memory cycles. Without it, any access whose
// offset is not a multiple of its size is rejected (resp_misaligned = 1)
// without touching memory.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write            1 = store, 0 = load
//   req_funct3           b/h/w/d/bu/hu/wu encoding
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and rejects)
//   resp_misaligned      request rejected as illegal/misaligned
//   dmem_*               memory strobes, NB-aligned address, lane data/enables,
//                        read data and completion
module lsu_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_misaligned,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [ADDR_W-1:0]   dmem_address,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_byte_enable,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_resp
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [2*NB-1:0] LANE_ONE = {{(2*NB-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t            state_reg;
  logic              write_reg;
  logic [2:0]        funct3_reg;
  logic [OFF_W-1:0]  off_reg;
  logic              split_reg;
  logic [NB-1:0]     be_hi_reg;
  logic [DATA_W-1:0] wdata_hi_reg;
  logic [DATA_W-1:0] rdata_lo_reg;

  // Byte-granular mask covering the low (1 << size_log2) bytes.
  function automatic logic [DATA_W-1:0] byte_keep(input logic [1:0] size_log2);
    logic [DATA_W-1:0] keep;
    for (int i = 0; i < NB; i++)
      keep[i*8 +: 8] = (i < (1 << size_log2)) ? 8'hFF : 8'h00;
    return keep;
  endfunction

  // Truncate to the access size and sign/zero extend. The sign bit is the
  // topmost kept bit, found as keep & ~(keep >> 1), so no variable index.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [2:0] f3);
    logic [DATA_W-1:0] keep;
    logic              sign;
    keep = byte_keep(f3[1:0]);
    sign = ~f3[2] & (|(v & keep & ~(keep >> 1)));
    return (v & keep) | ({DATA_W{sign}} & ~keep);
  endfunction

  // Request decode. Lane mask and store data are built 2*NB lanes wide so
  // the upper half directly gives the second beat of a split access.
  logic [3:0]          req_size;
  logic [OFF_W-1:0]    req_off;
  logic                req_illegal;
  logic                req_split;
  logic                req_reject;
  logic [2*NB-1:0]     req_lanes;
  logic [2*DATA_W-1:0] req_wdata_sh;
  logic [ADDR_W-1:0]   req_base;
`ifndef LSU_MISALIGN_SPLIT_EN
  logic [OFF_W-1:0]    req_align_mask;
`endif

  always_comb begin
    req_size     = 4'd1 << req_funct3[1:0];
    req_off      = req_addr[OFF_W-1:0];
    req_illegal  = (req_funct3 == 3'b111) || (int'(req_size) > NB);
    req_split    = (int'(req_off) + int'(req_size)) > NB;
    req_lanes    = ((LANE_ONE << req_size) - LANE_ONE) << req_off;
    req_wdata_sh = {{DATA_W{1'b0}}, req_wdata & byte_keep(req_funct3[1:0])}
                   << {req_off, 3'b000};
    req_base     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LSU_MISALIGN_SPLIT_EN
    req_reject   = req_illegal;
`else
    // size is a power of two <= NB here, so (size-1) truncated to OFF_W bits
    // is the alignment mask (size == NB wraps to all ones).
    req_align_mask = req_size[OFF_W-1:0] - {{(OFF_W-1){1'b0}}, 1'b1};
    req_reject     = req_illegal || ((req_off & req_align_mask) != '0);
`endif
  end

  // Load result: the two captures are concatenated in byte order and the
  // requested bytes shifted down from the original offset.
  logic [2*DATA_W-1:0] load_pair;
  logic [DATA_W-1:0]   load_ext;

  always_comb begin
    load_pair = (state_reg == ACC2) ? {dmem_rdata, rdata_lo_reg}
                                    : {{DATA_W{1'b0}}, dmem_rdata};
    load_ext  = extend(DATA_W'(load_pair >> {off_reg, 3'b000}), funct3_reg);
  end

  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      write_reg        <= 1'b0;
      funct3_reg       <= '0;
      off_reg          <= '0;
      split_reg        <= 1'b0;
      be_hi_reg        <= '0;
      wdata_hi_reg     <= '0;
      rdata_lo_reg     <= '0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_misaligned  <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg        <= req_write;
            funct3_reg       <= req_funct3;
            off_reg          <= req_off;
            split_reg        <= req_split;
            be_hi_reg        <= req_lanes[2*NB-1:NB];
            wdata_hi_reg     <= req_wdata_sh[2*DATA_W-1:DATA_W];
            dmem_address     <= req_base;
            dmem_byte_enable <= req_lanes[NB-1:0];
            dmem_wdata       <= req_wdata_sh[DATA_W-1:0];
            if (req_reject) begin
              state_reg       <= RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= '0;
            end else begin
              state_reg  <= ACC1;
              dmem_read  <= ~req_write;
              dmem_write <= req_write;
            end
          end
        end
        ACC1: begin
          if (dmem_resp) begin
            rdata_lo_reg <= dmem_rdata;
            if (split_reg) begin
              // Second beat: next word up, wrapping at the top of memory.
              state_reg        <= ACC2;
              dmem_address     <= dmem_address + ADDR_W'(NB);
              dmem_byte_enable <= be_hi_reg;
              dmem_wdata       <= wdata_hi_reg;
            end else begin
              state_reg  <= RESP;
              dmem_read  <= 1'b0;
              dmem_write <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= write_reg ? '0 : load_ext;
            end
          end
        end
        ACC2: begin
          if (dmem_resp) begin
            state_reg  <= RESP;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= write_reg ? '0 : load_ext;
          end
        end
        RESP: begin
          state_reg       <= IDLE;
          resp_valid      <= 1'b0;
          resp_misaligned <= 1'b0;
          resp_rdata      <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe -- self-checking bench for lsu_pipe (DATA_W = ADDR_W = 32).
// Directed vector table, reset corner sequences, then randomized requests
// checked against a byte-level reference model. Expectations follow the
// LSU_MISALIGN_SPLIT_EN setting the bench is compiled with.
module tb_lsu_pipe;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_misaligned;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] dmem_address;
  logic [DW-1:0] dmem_wdata;
  logic [NB-1:0] dmem_byte_enable;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_resp;

  int errors = 0;
  int checks = 0;

  lsu_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, r1, r2;
    int          d1, d2;
    logic        rej;
    int          nacc;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] addr2;
    logic [3:0]  be2;
    logic [31:0] wd2;
    logic [31:0] rdata;
  } txn_t;

  txn_t vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mkv(
      input logic wr, input logic [2:0] f3, input logic [31:0] addr, wdata, r1, r2,
      input int d1, d2, input logic rej, input int nacc,
      input logic [31:0] addr1, input logic [3:0] be1, input logic [31:0] wd1,
      input logic [31:0] addr2, input logic [3:0] be2, input logic [31:0] wd2,
      input logic [31:0] rdata);
    txn_t t;
    t.wr = wr; t.f3 = f3; t.addr = addr; t.wdata = wdata; t.r1 = r1; t.r2 = r2;
    t.d1 = d1; t.d2 = d2; t.rej = rej; t.nacc = nacc;
    t.addr1 = addr1; t.be1 = be1; t.wd1 = wd1;
    t.addr2 = addr2; t.be2 = be2; t.wd2 = wd2; t.rdata = rdata;
    return t;
  endfunction

  // Reference model: walk the accessed bytes one at a time, decide which
  // memory word each falls in, and collect lanes / data / result per byte.
  function automatic txn_t model(input txn_t t);
    int          size;
    logic [31:0] a, base, val;
    int          lane;
    size  = 1 << t.f3[1:0];
    t.rej = (t.f3 == 3'b111) || (size > NB);
`ifndef LSU_MISALIGN_SPLIT_EN
    if ((t.addr % size) != 0) t.rej = 1'b1;
`endif
    base    = t.addr & ~(NB - 1);
    t.addr1 = base;
    t.addr2 = base + NB;
    t.be1 = '0; t.be2 = '0; t.wd1 = '0; t.wd2 = '0;
    t.nacc = 1;
    val = '0;
    if (!t.rej) begin
      for (int k = 0; k < size; k++) begin
        a    = t.addr + 32'(k);
        lane = int'(a % NB);
        if ((a & ~(NB - 1)) == base) begin
          t.be1[lane] = 1'b1;
          t.wd1[lane*8 +: 8] = t.wdata[k*8 +: 8];
          val[k*8 +: 8] = t.r1[lane*8 +: 8];
        end else begin
          t.nacc = 2;
          t.be2[lane] = 1'b1;
          t.wd2[lane*8 +: 8] = t.wdata[k*8 +: 8];
          val[k*8 +: 8] = t.r2[lane*8 +: 8];
        end
      end
      if (!t.f3[2] && size < NB && val[8*size-1])
        val = val | ~((32'd1 << (8*size)) - 32'd1);
    end else begin
      t.nacc = 0;
    end
    t.rdata = (t.rej || t.wr) ? 32'd0 : val;
    return t;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Drives one request from IDLE, plays the memory, checks every cycle.
  task automatic run_txn(input txn_t t, input int idx);
    logic [31:0] a_exp, wd_exp;
    logic [3:0]  be_exp;
    int          d;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    req_valid = 1'b1; req_write = t.wr; req_funct3 = t.f3;
    req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must have latched them.
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int n = 0; n < t.nacc; n++) begin
      a_exp  = (n == 0) ? t.addr1 : t.addr2;
      be_exp = (n == 0) ? t.be1 : t.be2;
      wd_exp = (n == 0) ? t.wd1 : t.wd2;
      d      = (n == 0) ? t.d1 : t.d2;
      for (int c = 0; c <= d; c++) begin
        check("dmem_read", 32'(dmem_read), 32'(!t.wr));
        check("dmem_write", 32'(dmem_write), 32'(t.wr));
        check("dmem_address", dmem_address, a_exp);
        check("dmem_byte_enable", 32'(dmem_byte_enable), 32'(be_exp));
        if (t.wr) check("dmem_wdata", dmem_wdata & lane_bits(be_exp), wd_exp);
        check("busy_ready", 32'(req_ready), 32'd0);
        check("busy_resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'($urandom);  // must be ignored while busy
        if (c == d) begin
          dmem_resp = 1'b1;
          dmem_rdata = (n == 0) ? t.r1 : t.r2;
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = $urandom;
      end
    end
    req_valid = 1'b0;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_misaligned", 32'(resp_misaligned), 32'(t.rej));
    check("resp_rdata", resp_rdata, t.rdata);
    check("resp_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("resp_ready", 32'(req_ready), 32'd0);
    dmem_resp = 1'($urandom);  // stray completion, must be ignored
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
    check("back_idle", 32'(req_ready), 32'd1);
    $display("txn %0d: %s f3=%0d addr=%h nacc=%0d rdata=%h mis=%0b",
             idx, t.wr ? "st" : "ld", t.f3, t.addr, t.nacc, resp_rdata, t.rej);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_mis"}, 32'(resp_misaligned), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_strobes"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    check({tag, "_address"}, dmem_address, 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_be"}, 32'(dmem_byte_enable), 32'd0);
  endtask

  initial begin
    txn_t t;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: inputs followed by hand-derived expectations.
    vec.push_back(mkv(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF));
    vec.push_back(mkv(0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 0, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80));
    vec.push_back(mkv(0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 1, 0, 0, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'h00000080));
    vec.push_back(mkv(1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 0, 1, 32'h100, 4'hC, 32'hABCD0000, 0, 0, 0, 0));
    vec.push_back(mkv(0, 3'b101, 32'h202, 0, 32'h80010000, 0, 2, 0, 0, 1, 32'h200, 4'hC, 0, 0, 0, 0, 32'h00008001));
    vec.push_back(mkv(0, 3'b001, 32'h202, 0, 32'h80010000, 0, 0, 0, 0, 1, 32'h200, 4'hC, 0, 0, 0, 0, 32'hFFFF8001));
    vec.push_back(mkv(1, 3'b000, 32'h101, 32'h000000AB, 0, 0, 0, 0, 0, 1, 32'h100, 4'h2, 32'h0000AB00, 0, 0, 0, 0));
    vec.push_back(mkv(0, 3'b110, 32'h104, 0, 32'h80000000, 0, 0, 0, 0, 1, 32'h104, 4'hF, 0, 0, 0, 0, 32'h80000000));
    vec.push_back(mkv(0, 3'b011, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mkv(0, 3'b111, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mkv(1, 3'b111, 32'h204, 32'h12345678, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vec.push_back(mkv(0, 3'b001, 32'h101, 0, 32'h12345678, 0, 0, 0, 0, 1, 32'h100, 4'h6, 0, 0, 0, 0, 32'h00003456));
    vec.push_back(mkv(0, 3'b010, 32'h0FE, 0, 32'h22221111, 32'h44443333, 0, 1, 0, 2, 32'h0FC, 4'hC, 0, 32'h100, 4'h3, 0, 32'h33332222));
    vec.push_back(mkv(1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0, 0, 1, 0, 0, 2, 32'hFFFFFFFC, 4'hC, 32'h33440000, 32'h0, 4'h3, 32'h00001122, 0));
`else
    vec.push_back(mkv(0, 3'b001, 32'h101, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mkv(0, 3'b010, 32'h0FE, 0, 32'h22221111, 32'h44443333, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mkv(1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    foreach (vec[i]) run_txn(vec[i], i);

    // Reset during ACC1 with the memory never answering.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h300; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("acc1_strobe_before_rst", 32'(dmem_read), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D;  // late completion
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("late_resp_valid", 32'(resp_valid), 32'd0);
    check("late_resp_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("late_resp_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("late_resp_valid2", 32'(resp_valid), 32'd0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 200; i++) begin
      t.wr    = 1'($urandom);
      t.f3    = 3'($urandom_range(0, 7));
      t.addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7)))
                                            : $urandom;
      t.wdata = $urandom;
      t.r1    = $urandom;
      t.r2    = $urandom;
      t.d1    = int'($urandom_range(0, 3));
      t.d2    = int'($urandom_range(0, 3));
      t       = model(t);
      run_txn(t, 100 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
